tt_um_ev_counter_gen2: RTL
==========================

# tt_um_ev_counter_gen2

Parametrised successor to the team's event counter, packaged as a TinyTapeout user tile. It provides a WIDTH-bit up/down counter with a prescaler, wrap or saturate mode, and byte-wise load through the uio bus. An optional compare register drives match flags. All counter and status state is read one byte at a time on uo_out, selected by ui_in.

## Interface
Parameters:
- WIDTH, 16: counter width; legal 8..24.
- PRESCALE, 1: count tick every PRESCALE enabled cycles; legal 1..256.

Ports:
- clk  in  1  tile clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- ena  in  1  tile enable. When 0, no count, load, compare write or clear takes effect; registers hold.
- ui_in  in  8  controls:
  - [0] en
  - [1] dir (1 = up)
  - [2] mode (0 = wrap, 1 = saturate)
  - [3] load strobe
  - [5:4] byte select
  - [6] compare-write strobe
  - [7] clear
- uo_out  out  8  selected read byte.
- uio_in  in  8  load / compare data byte.
- uio_out  out  8  constant 0.
- uio_oe  out  8  constant 0 (uio is input only).

## Operation
Input registration:
- ui_in and uio_in are registered every clk (ui_q, uio_q), regardless of ena. All actions use the registered copies.
- ui_q is held one further cycle (ui_p) for edge detection of [3], [6] and [7].

Prescaler:
- Counts enabled cycles (ena & en_q) from 0 to PRESCALE-1.
- Issues a tick when it wraps to 0.
- Resets to 0 on clear.
- Holds while en_q = 0.

Counter update, in priority order (at most one per cycle):
- Clear: rising edge of ui_q[7]. cnt = 0; wrap_sticky and match_sticky = 0.
- Load: rising edge of ui_q[3]. Byte sel of cnt = uio_q. A sel selecting byte 3, or a byte at or above WIDTH, is ignored.
- Tick: up adds 1, down subtracts 1.
  - mode 0 (wrap): modulo 2^WIDTH. Crossing MAX→0 or 0→MAX sets wrap_sticky.
  - mode 1 (saturate): cnt holds at MAX when up and at 0 when down. wrap_sticky is not set.
- When load or clear coincides with a tick, the tick is lost. The prescaler still advances.

Compare (see Configuration):
- Rising edge of ui_q[6] writes uio_q into byte sel of cmp. Independent of counter priority.
- match = (cnt == cmp).
- match_sticky sets on any cycle where match = 1.

Read mux, uo_out by sel:
- 0/1/2: cnt[7:0], cnt[15:8], cnt[23:16]. Bits at or above WIDTH read 0.
- 3: status byte:
  - [0] match
  - [1] match_sticky
  - [2] wrap_sticky
  - [3] at_bound: cnt==MAX if dir=1, cnt==0 if dir=0
  - [4] dir_q
  - [5] mode_q
  - [6] en_q
  - [7] 0

## Timing
Reset values:
- cnt = 0
- cmp = all ones
- prescaler = 0
- ui_q, ui_p, uio_q = 0
- stickies = 0
- uo_out = 0x00 (sel = 0, cnt = 0)
- uio_out = 0, uio_oe = 0

Latency:
- A ui_in/uio_in change is sampled at edge k and acts at edge k+1.
- uo_out is combinational from registers, so it is valid after edge k+1.
- A sel change is visible on uo_out after edge k.

Clocking and edges:
- A strobe held high acts once. It must return low for at least one cycle before it acts again.
- With PRESCALE = N and en held high, cnt changes every N cycles. The first change is N cycles after en_q rises.

Reset and enable:
- Reset mid-count returns every register to its reset value immediately.
- No edge is detected on the first cycle after reset release unless ui_in is high then.
- ena low freezes the counter, prescaler and stickies. Input registers keep sampling, so a strobe edge that occurs while ena = 0 is lost.

## Configuration
- EV_COUNTER_CMP_EN defined: cmp register, compare-write strobe, match and match_sticky are implemented as described.
- Not defined: no cmp register is built, ui_in[6] is ignored, and status bits [0] and [1] read 0. All other behaviour is unchanged.

## Test plan
All scenarios use WIDTH = 16, PRESCALE = 1 unless stated.
- Reset, then en = 1, dir = 1, mode = 0 for 10 cycles → cnt = 10 (uo_out 0x0A with sel = 0); sel = 1 → 0x00.
- Load 0xFF into byte 0 and 0xFF into byte 1 (two strobes), then count up one tick → cnt = 0x0000; status bit 2 = 1. In mode 1, the same sequence holds cnt at 0xFFFF with status bit 3 = 1.
- dir = 0, mode = 1, from cnt = 0 → cnt stays 0, no wrap_sticky. With mode = 0 → cnt = 0xFFFF, wrap_sticky = 1.
- With EV_COUNTER_CMP_EN: write cmp = 0x0005 and count up from 0 → status bit 0 is high only while cnt = 5; bit 1 stays high afterwards until clear. Without the macro, both bits are always 0.
- PRESCALE = 4: en high for 16 cycles → cnt = 4. Clear strobe mid-run → cnt = 0, stickies 0, and the next increment arrives 4 cycles later.
- Load strobe coincident with a tick → the loaded byte wins and no increment occurs that cycle. ena = 0 for 5 cycles → cnt unchanged.

Source files
------------

// File: rtl/tt_um_ev_counter_gen2.sv
// Event counter tile: WIDTH-bit up/down counter with prescaler, wrap/saturate, byte load and byte readback.
// Inputs act one cycle after registration; uo_out is combinational from registers. EV_COUNTER_CMP_EN adds compare/match.
module tt_um_ev_counter_gen2 #(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  // Replace byte s of base with d; bytes beyond WIDTH (and byte 3) simply have no bits to hit.
  function automatic logic [WIDTH-1:0] put_byte(input logic [WIDTH-1:0] base,
                                                input logic [1:0] s,
                                                input logic [7:0] d);
    put_byte = base;
    for (int b = 0; b < WIDTH; b++) begin
      if (b / 8 == int'(s)) put_byte[b] = d[b % 8];
    end
  endfunction

  logic [7:0] ui_q, ui_p, uio_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ui_q  <= '0;
      ui_p  <= '0;
      uio_q <= '0;
    end else begin
      ui_q  <= ui_in;
      ui_p  <= ui_q;
      uio_q <= uio_in;
    end
  end

  logic       en_q, dir_q, mode_q;
  logic [1:0] sel;
  logic       clr_rise, load_rise;

  assign en_q      = ui_q[0];
  assign dir_q     = ui_q[1];
  assign mode_q    = ui_q[2];
  assign sel       = ui_q[5:4];
  assign clr_rise  = ui_q[7] & ~ui_p[7];
  assign load_rise = ui_q[3] & ~ui_p[3];

  logic [PW-1:0] pre;
  logic          tick;

  assign tick = ena && en_q && (pre == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (ena) begin
      if (clr_rise)            pre <= '0;
      else if (en_q)           pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
    end
  end

  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic             wrap_sticky, wrap_nxt;
  logic             cnt_max, cnt_zero, at_bound;

  assign cnt_max  = (cnt == CNT_MAX);
  assign cnt_zero = (cnt == '0);
  assign at_bound = dir_q ? cnt_max : cnt_zero;

  // A load or clear strobe consumes the cycle, so a coincident tick is dropped.
  always_comb begin
    cnt_nxt  = cnt;
    wrap_nxt = wrap_sticky;
    if (clr_rise) begin
      cnt_nxt  = '0;
      wrap_nxt = 1'b0;
    end else if (load_rise) begin
      cnt_nxt = put_byte(cnt, sel, uio_q);
    end else if (tick) begin
      if (dir_q) begin
        if (!cnt_max) begin
          cnt_nxt = cnt + WIDTH'(1);
        end else if (!mode_q) begin
          cnt_nxt  = '0;
          wrap_nxt = 1'b1;
        end
      end else begin
        if (!cnt_zero) begin
          cnt_nxt = cnt - WIDTH'(1);
        end else if (!mode_q) begin
          cnt_nxt  = CNT_MAX;
          wrap_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      wrap_sticky <= 1'b0;
    end else if (ena) begin
      cnt         <= cnt_nxt;
      wrap_sticky <= wrap_nxt;
    end
  end

  logic match, match_sticky;

`ifdef EV_COUNTER_CMP_EN
  logic [WIDTH-1:0] cmp;
  logic             cmpw_rise;
  logic [4:0]       unused_p;

  assign cmpw_rise = ui_q[6] & ~ui_p[6];
  assign match     = (cnt == cmp);
  assign unused_p  = {ui_p[5:4], ui_p[2:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp          <= '1;
      match_sticky <= 1'b0;
    end else if (ena) begin
      if (cmpw_rise) cmp <= put_byte(cmp, sel, uio_q);
      if (clr_rise)      match_sticky <= 1'b0;
      else if (match)    match_sticky <= 1'b1;
    end
  end
`else
  logic [6:0] unused_p;

  assign match        = 1'b0;
  assign match_sticky = 1'b0;
  assign unused_p     = {ui_q[6], ui_p[6:4], ui_p[2:0]};
`endif

  logic [23:0] cnt_ext;
  assign cnt_ext = 24'(cnt);

  always_comb begin
    case (sel)
      2'd0:    uo_out = cnt_ext[7:0];
      2'd1:    uo_out = cnt_ext[15:8];
      2'd2:    uo_out = cnt_ext[23:16];
      default: uo_out = {1'b0, en_q, mode_q, dir_q, at_bound, wrap_sticky, match_sticky, match};
    endcase
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule
